// File: rtl/ad_window_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : ad_window_feeder
//  Description : Absolute-difference front end for the running-window SAD
//                accumulator. Per accepted pixel pair it presents the entering
//                AD term (ad_new) and the term leaving the window (ad_old).
//  Revision    : 1.0 - initial release
// ============================================================================
module ad_window_feeder #(
    parameter int PIXEL_BITS = 8,
    parameter int AD_BITS    = 12,
    parameter int WINDOW     = 9,
    parameter int ADDR_BITS  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pix_valid,
    input  logic                  line_start,
    input  logic [PIXEL_BITS-1:0] left_pix,
    input  logic [PIXEL_BITS-1:0] right_pix,
    output logic [AD_BITS-1:0]    ad_new,
    output logic [AD_BITS-1:0]    ad_old,
    output logic                  out_valid,
    output logic                  first_out,
    output logic                  window_full
);

    // Storage is sized to the full address space so any pointer value is a
    // legal index; only the first WINDOW entries are ever used.
    localparam int                 c_DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] c_LAST = ADDR_BITS'(WINDOW - 1);
    localparam logic [ADDR_BITS:0]   c_WIN  = (ADDR_BITS + 1)'(WINDOW);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [AD_BITS-1:0]    r_mem [0:c_DEPTH-1];
    logic [ADDR_BITS-1:0]  r_wr_ptr;
    logic [ADDR_BITS:0]    r_fill_cnt;
    logic [0:0]            r_state;
    logic [AD_BITS-1:0]    r_ad_new;
    logic [AD_BITS-1:0]    r_ad_old;
    logic                  r_out_valid;
    logic                  r_first_out;
    logic                  r_window_full;

    logic [PIXEL_BITS-1:0] w_diff;
    logic [AD_BITS-1:0]    w_ad;
    logic [AD_BITS-1:0]    w_ad_old;
    logic [ADDR_BITS-1:0]  w_ptr_nxt;
    logic [ADDR_BITS:0]    w_fill_nxt;
    logic [0:0]            w_state_nxt;

    // Unsigned absolute difference, zero-extended to the output width
    always_comb begin
        w_diff = (left_pix >= right_pix) ? (left_pix - right_pix)
                                         : (right_pix - left_pix);
        w_ad   = AD_BITS'(w_diff);
    end

    // Leaving term: the slot about to be overwritten holds the AD accepted
    // WINDOW samples ago, but it only belongs to this line once in RUN.
    always_comb begin
        w_ad_old = '0;
        if (r_state == S_RUN && !line_start) begin
            w_ad_old = r_mem[r_wr_ptr];
        end
    end

    // Next pointer, fill count and state for an accepted sample
    always_comb begin
        w_ptr_nxt   = (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
        w_fill_nxt  = r_fill_cnt;
        w_state_nxt = r_state;
        if (line_start) begin
            // Pointer is deliberately left alone: addressing is relative.
            w_fill_nxt  = (ADDR_BITS + 1)'(1);
            w_state_nxt = S_FILL;
        end else if (r_state == S_FILL) begin
            w_fill_nxt = r_fill_cnt + 1'b1;
            if (r_fill_cnt + 1'b1 == c_WIN) begin
                w_state_nxt = S_RUN;
            end
        end
    end

    // Circular AD buffer; the read above sees the old contents of the slot
    always_ff @(posedge clock) begin
        if (!reset && pix_valid) begin
            r_mem[r_wr_ptr] <= w_ad;
        end
    end

    // Control state and registered outputs; idle cycles emit zero terms
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_fill_cnt    <= '0;
            r_state       <= S_FILL;
            r_ad_new      <= '0;
            r_ad_old      <= '0;
            r_out_valid   <= 1'b0;
            r_first_out   <= 1'b0;
            r_window_full <= 1'b0;
        end else if (pix_valid) begin
            r_wr_ptr      <= w_ptr_nxt;
            r_fill_cnt    <= w_fill_nxt;
            r_state       <= w_state_nxt;
            r_ad_new      <= w_ad;
            r_ad_old      <= w_ad_old;
            r_out_valid   <= 1'b1;
            r_first_out   <= line_start;
            r_window_full <= (w_state_nxt == S_RUN);
        end else begin
            r_ad_new      <= '0;
            r_ad_old      <= '0;
            r_out_valid   <= 1'b0;
            r_first_out   <= 1'b0;
        end
    end

    assign ad_new      = r_ad_new;
    assign ad_old      = r_ad_old;
    assign out_valid   = r_out_valid;
    assign first_out   = r_first_out;
    assign window_full = r_window_full;

endmodule
`default_nettype wire

// File: tb/tb_ad_window_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ad_window_feeder
//  Description : Self-checking bench for ad_window_feeder (WINDOW=3 and 16)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ad_window_feeder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pix_valid = 1'b0;
    logic       line_start = 1'b0;
    logic [7:0] left_pix = '0;
    logic [7:0] right_pix = '0;

    logic [11:0] an3, ao3, an16, ao16;
    logic        ov3, fo3, wf3, ov16, fo16, wf16;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          win = 3;
    int          hist[$];
    logic [11:0] e_new, e_old;
    logic        e_ov, e_fo, e_wf;
    int          acc;

    always #5 clock = ~clock;

    ad_window_feeder #(.PIXEL_BITS(8), .AD_BITS(12), .WINDOW(3), .ADDR_BITS(4)) d3 (
        .clock(clock), .reset(reset), .pix_valid(pix_valid), .line_start(line_start),
        .left_pix(left_pix), .right_pix(right_pix), .ad_new(an3), .ad_old(ao3),
        .out_valid(ov3), .first_out(fo3), .window_full(wf3));

    ad_window_feeder #(.PIXEL_BITS(8), .AD_BITS(12), .WINDOW(16), .ADDR_BITS(4)) d16 (
        .clock(clock), .reset(reset), .pix_valid(pix_valid), .line_start(line_start),
        .left_pix(left_pix), .right_pix(right_pix), .ad_new(an16), .ad_old(ao16),
        .out_valid(ov16), .first_out(fo16), .window_full(wf16));

    // Model: the ADs seen on the current line; the leaving term is the one
    // exactly `win` entries back, the window is full once `win` are present.
    function automatic void model_reset();
        hist.delete();
        e_new = '0; e_old = '0; e_ov = 1'b0; e_fo = 1'b0; e_wf = 1'b0;
        acc = 0;
    endfunction

    function automatic void model_step(input bit v, input bit ls, input int l, input int r);
        int ad;
        if (!v) begin
            e_new = '0; e_old = '0; e_ov = 1'b0; e_fo = 1'b0;
        end else begin
            if (ls) hist.delete();
            ad = (l > r) ? l - r : r - l;
            hist.push_back(ad);
            e_new = 12'(ad);
            e_old = (hist.size() > win) ? 12'(hist[hist.size() - 1 - win]) : 12'd0;
            e_ov  = 1'b1;
            e_fo  = ls;
            e_wf  = (hist.size() >= win);
        end
    endfunction

    function automatic int direct_sum();
        int s = 0;
        int n = (hist.size() < win) ? hist.size() : win;
        for (int i = 0; i < n; i++) s += hist[hist.size() - 1 - i];
        return s;
    endfunction

    task automatic drive(input bit v, input bit ls, input int l, input int r);
        pix_valid = v; line_start = ls; left_pix = 8'(l); right_pix = 8'(r);
        model_step(v, ls, l, r);
        @(posedge clock); #1;
    endtask

    // Random pixel pair whose absolute difference is k
    task automatic drive_ad(input bit ls, input int k);
        int b = $urandom_range(0, 255 - k);
        if ($urandom_range(0, 1) == 1) drive(1'b1, ls, b + k, b);
        else                            drive(1'b1, ls, b, b + k);
    endtask

    task automatic do_reset();
        reset = 1'b1; pix_valid = 1'b0; line_start = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ov3, fo3, wf3, an3, ao3, ov16, fo16, wf16, an16, ao16} !== '0) begin
            errors++;
            $display("FAIL reset: got ov=%b fo=%b wf=%b new=%0d old=%0d want all zero",
                     ov3, fo3, wf3, an3, ao3);
        end
    endtask

    task automatic test_basic_ad();
        int want [2] = '{7, 247};
        win = 3; do_reset();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(1'b1, 1'b0, 10, 3); else drive(1'b1, 1'b0, 3, 250);
            checks++;
            if ({ov3, fo3, an3, ao3} !== {1'b1, 1'b0, 12'(want[i]), 12'd0}) begin
                errors++;
                $display("FAIL basic[%0d]: got ov=%b fo=%b new=%0d old=%0d want ov=1 fo=0 new=%0d old=0",
                         i, ov3, fo3, an3, ao3, want[i]);
            end
        end
    endtask

    task automatic test_fill_run(input int gap);
        int want_acc [6] = '{1, 3, 6, 9, 12, 15};
        win = 3; do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_ad(i == 0, i + 1);
            for (int g = 0; g <= gap; g++) begin
                if (g > 0) drive(1'b0, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255));
                if (ov3) acc = fo3 ? int'(an3) - int'(ao3) : acc + int'(an3) - int'(ao3);
                checks++;
                if ({ov3, fo3, wf3, an3, ao3} !== {e_ov, e_fo, e_wf, e_new, e_old}) begin
                    errors++;
                    $display("FAIL fill_run(gap=%0d)[%0d.%0d]: got ov=%b fo=%b wf=%b new=%0d old=%0d want ov=%b fo=%b wf=%b new=%0d old=%0d",
                             gap, i, g, ov3, fo3, wf3, an3, ao3, e_ov, e_fo, e_wf, e_new, e_old);
                end
                checks++;
                if (acc !== want_acc[i] || acc !== direct_sum()) begin
                    errors++;
                    $display("FAIL fill_run_acc(gap=%0d)[%0d.%0d]: got %0d want %0d", gap, i, g, acc, want_acc[i]);
                end
            end
        end
    endtask

    task automatic test_restart();
        int ads [9] = '{1, 2, 3, 4, 5, 9, 8, 7, 6};
        win = 3; do_reset();
        for (int i = 0; i < 9; i++) begin
            drive_ad(i == 0 || i == 5, ads[i]);
            if (ov3) acc = fo3 ? int'(an3) - int'(ao3) : acc + int'(an3) - int'(ao3);
            checks++;
            if ({ov3, fo3, wf3, an3, ao3} !== {e_ov, e_fo, e_wf, e_new, e_old} || acc !== direct_sum()) begin
                errors++;
                $display("FAIL restart[%0d]: got fo=%b wf=%b new=%0d old=%0d acc=%0d want fo=%b wf=%b new=%0d old=%0d acc=%0d",
                         i, fo3, wf3, an3, ao3, acc, e_fo, e_wf, e_new, e_old, direct_sum());
            end
        end
    endtask

    task automatic test_reset_midrun();
        win = 3; do_reset();
        for (int i = 0; i < 5; i++) drive_ad(i == 0, i + 1);
        reset = 1'b1; pix_valid = 1'b1; line_start = 1'b0; left_pix = 8'd200; right_pix = 8'd0;
        model_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        checks++;
        if ({ov3, fo3, wf3, an3, ao3} !== '0) begin
            errors++;
            $display("FAIL reset_midrun: got ov=%b fo=%b wf=%b new=%0d old=%0d want all zero",
                     ov3, fo3, wf3, an3, ao3);
        end
        for (int i = 0; i < 4; i++) begin
            drive_ad(1'b0, 20 + i);
            checks++;
            if ({ov3, fo3, wf3, an3, ao3} !== {e_ov, e_fo, e_wf, e_new, e_old}) begin
                errors++;
                $display("FAIL reset_refill[%0d]: got fo=%b wf=%b new=%0d old=%0d want fo=%b wf=%b new=%0d old=%0d",
                         i, fo3, wf3, an3, ao3, e_fo, e_wf, e_new, e_old);
            end
        end
    endtask

    task automatic test_wrap_stress();
        logic [11:0] seen[$];
        win = 16; do_reset();
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0)
                drive(1'b0, 1'b0, 0, 0);
            drive(1'b1, i == 0, $urandom_range(0, 255), $urandom_range(0, 255));
            seen.push_back(an16);
            acc = fo16 ? int'(an16) - int'(ao16) : acc + int'(an16) - int'(ao16);
            checks++;
            if ({ov16, fo16, wf16, an16, ao16} !== {e_ov, e_fo, e_wf, e_new, e_old}
                || ao16 !== ((i >= 16) ? seen[i - 16] : 12'd0) || acc !== direct_sum()) begin
                errors++;
                $display("FAIL wrap[%0d]: got fo=%b wf=%b new=%0d old=%0d acc=%0d want fo=%b wf=%b new=%0d old=%0d acc=%0d",
                         i, fo16, wf16, an16, ao16, acc, e_fo, e_wf, e_new, e_old, direct_sum());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_ad();
        test_fill_run(0);
        test_fill_run(2);
        test_restart();
        test_reset_midrun();
        test_wrap_stress();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
